// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/stall handling and the IF/ID
// pipeline register, with a terminal HALTED state left only through reset.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        jr,
  input  logic        jmp,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  input  logic [31:0] jmp_target,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        valid_out,
  output logic        halted
);

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_npc;
  logic        r_valid;
  logic        r_halted;
  logic        r_iren;

  logic        w_redirect;
  logic [31:0] w_sel_target;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_redirect   = jr | jmp | branch_taken;
  assign w_sel_target = jr  ? jr_target  :
                        jmp ? jmp_target : branch_target;
  // Targets are word-aligned by dropping the low two bits.
  assign w_target     = w_sel_target & 32'hFFFF_FFFC;
  assign w_pc_plus4   = r_pc + 32'd4;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= FETCH;
      r_pc     <= PC_INIT;
      r_instr  <= '0;
      r_npc    <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_iren   <= 1'b1;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_instr <= '0;
            r_npc   <= '0;
            r_valid <= 1'b0;
          end else if (halt) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
            r_iren   <= 1'b0;
            r_instr  <= '0;
            r_npc    <= '0;
            r_valid  <= 1'b0;
          end else begin
            if (ihit && !stall) begin
              r_pc <= w_pc_plus4;
            end
            // Flush beats stall for IF/ID, but the PC still follows ihit/stall.
            if (flush) begin
              r_instr <= '0;
              r_npc   <= '0;
              r_valid <= 1'b0;
            end else if (!stall) begin
              if (ihit) begin
                r_instr <= iload;
                r_npc   <= w_pc_plus4;
                r_valid <= 1'b1;
              end else begin
                r_instr <= '0;
                r_npc   <= '0;
                r_valid <= 1'b0;
              end
            end
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign iaddr     = r_pc;
  assign iREN      = r_iren;
  assign instr_out = r_instr;
  assign npc_out   = r_npc;
  assign valid_out = r_valid;
  assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: stimulus pushes expected post-edge
// state into a queue; an independent monitor pops and compares after each edge.
module tb_fetch_stage;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall;
  logic        flush;
  logic        jr;
  logic        jmp;
  logic        branch_taken;
  logic [31:0] jr_target;
  logic [31:0] jmp_target;
  logic [31:0] branch_target;
  logic        halt;
  logic [31:0] instr_out;
  logic [31:0] npc_out;
  logic        valid_out;
  logic        halted;

  fetch_stage #(.PC_INIT(32'h00000000)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ihit         (ihit),
    .iload        (iload),
    .iREN         (iREN),
    .iaddr        (iaddr),
    .stall        (stall),
    .flush        (flush),
    .jr           (jr),
    .jmp          (jmp),
    .branch_taken (branch_taken),
    .jr_target    (jr_target),
    .jmp_target   (jmp_target),
    .branch_target(branch_target),
    .halt         (halt),
    .instr_out    (instr_out),
    .npc_out      (npc_out),
    .valid_out    (valid_out),
    .halted       (halted)
  );

  typedef struct {
    int          id;
    logic [31:0] iaddr;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;
  bit   done  = 0;

  localparam logic [31:0] I1 = 32'h20010005;
  localparam logic [31:0] I2 = 32'hAABB0001;
  localparam logic [31:0] I3 = 32'h33330003;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, id, act, want);
    end
  endtask

  // Monitor: outputs are registered, so every edge presents a new observation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("iaddr",     e.id, iaddr,             e.iaddr);
        chk("instr_out", e.id, instr_out,         e.instr);
        chk("npc_out",   e.id, npc_out,           e.npc);
        chk("valid_out", e.id, {31'd0, valid_out}, {31'd0, e.valid});
        chk("halted",    e.id, {31'd0, halted},    {31'd0, e.halted});
        chk("iREN",      e.id, {31'd0, iREN},      {31'd0, ~e.halted});
      end
    end
  end

  task automatic idle();
    RST = 1'b0; ihit = 1'b0; iload = '0; stall = 1'b0; flush = 1'b0;
    jr = 1'b0; jmp = 1'b0; branch_taken = 1'b0;
    jr_target = '0; jmp_target = '0; branch_target = '0; halt = 1'b0;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] i, input logic [31:0] n,
                      input logic v, input logic h);
    exp_t e;
    step_id++;
    e.id = step_id; e.iaddr = a; e.instr = i; e.npc = n; e.valid = v; e.halted = h;
    q.push_back(e);
    @(negedge CLK);
  endtask

  initial begin
    idle();
    RST = 1'b1; ihit = 1'b1; iload = I1; jmp = 1'b1; jmp_target = 32'h700;
    step(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);                       // 1 reset wins

    idle(); ihit = 1'b1; iload = I1;
    step(32'h4, I1, 32'h4, 1'b1, 1'b0);                          // 2 sequential
    step(32'h8, I1, 32'h8, 1'b1, 1'b0);                          // 3

    idle();
    repeat (3) step(32'h8, 32'h0, 32'h0, 1'b0, 1'b0);            // 4-6 miss
    ihit = 1'b1; iload = I2;
    step(32'hC, I2, 32'hC, 1'b1, 1'b0);                          // 7

    idle(); stall = 1'b1; ihit = 1'b1; iload = 32'h00001111;
    step(32'hC, I2, 32'hC, 1'b1, 1'b0);                          // 8 stall holds
    step(32'hC, I2, 32'hC, 1'b1, 1'b0);                          // 9

    idle(); ihit = 1'b1; iload = I3;
    step(32'h10, I3, 32'h10, 1'b1, 1'b0);                        // 10
    idle(); flush = 1'b1; ihit = 1'b1; iload = I1;
    step(32'h14, 32'h0, 32'h0, 1'b0, 1'b0);                      // 11 flush, PC moves

    idle(); jr = 1'b1; jr_target = 32'h100; jmp = 1'b1; jmp_target = 32'h200;
    branch_taken = 1'b1; branch_target = 32'h300; stall = 1'b1; ihit = 1'b1; iload = I1;
    step(32'h100, 32'h0, 32'h0, 1'b0, 1'b0);                     // 12 jr priority
    idle(); jmp = 1'b1; jmp_target = 32'h202; branch_taken = 1'b1; branch_target = 32'h300;
    ihit = 1'b1; iload = I1;
    step(32'h200, 32'h0, 32'h0, 1'b0, 1'b0);                     // 13 jmp over branch
    idle(); branch_taken = 1'b1; branch_target = 32'h00000043;
    step(32'h40, 32'h0, 32'h0, 1'b0, 1'b0);                      // 14 alignment
    idle(); ihit = 1'b1; iload = I1;
    step(32'h44, I1, 32'h44, 1'b1, 1'b0);                        // 15

    idle(); branch_taken = 1'b1; branch_target = 32'hFFFFFFFF;
    step(32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b0);                // 16
    idle(); ihit = 1'b1; iload = I2;
    step(32'h0, I2, 32'h0, 1'b1, 1'b0);                          // 17 wrap

    idle(); halt = 1'b1; branch_taken = 1'b1; branch_target = 32'h80; ihit = 1'b1; iload = I1;
    step(32'h80, 32'h0, 32'h0, 1'b0, 1'b0);                      // 18 redirect beats halt
    idle(); ihit = 1'b1; iload = I3;
    step(32'h84, I3, 32'h84, 1'b1, 1'b0);                        // 19
    idle(); halt = 1'b1; ihit = 1'b1; iload = I1;
    step(32'h84, 32'h0, 32'h0, 1'b0, 1'b1);                      // 20 halt
    idle(); jmp = 1'b1; jmp_target = 32'h500; ihit = 1'b1; iload = I1; flush = 1'b1;
    step(32'h84, 32'h0, 32'h0, 1'b0, 1'b1);                      // 21 ignored
    idle(); ihit = 1'b1; iload = I2;
    step(32'h84, 32'h0, 32'h0, 1'b0, 1'b1);                      // 22

    idle(); RST = 1'b1; jmp = 1'b1; jmp_target = 32'h500;
    step(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);                       // 23 reset from HALTED
    idle(); ihit = 1'b1; iload = I1;
    step(32'h4, I1, 32'h4, 1'b1, 1'b0);                          // 24

    idle();
    @(posedge CLK);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
